// File: rtl/port_alloc_mc_pkg.sv
// Shared types, sizes and helpers for the multicast port allocator.
// STARVE_TH / STARVE_W are only used when STARVE_GUARD_EN is defined.
package port_alloc_mc_pkg;
    localparam int NUM_PORT  = 4;
    localparam int RANK_W    = 2;
    localparam int STARVE_TH = 7;
    localparam int STARVE_W  = 3;

    typedef logic [NUM_PORT-1:0] port_vec_t;
    typedef logic [RANK_W-1:0]   chan_idx_t;

    // Isolates the lowest set bit; zero in gives zero out.
    function automatic port_vec_t lowest_bit(input port_vec_t v);
        return v & (~v + 4'b0001);
    endfunction
endpackage

// File: rtl/port_alloc_mc_if.sv
// Flit-request / crossbar-select bundle between the router and the allocator.
interface port_alloc_mc_if;
    import port_alloc_mc_pkg::*;

    port_vec_t in_valid;
    port_vec_t ppv_0;
    port_vec_t ppv_1;
    port_vec_t ppv_2;
    port_vec_t ppv_3;
    logic      out_valid;
    port_vec_t allocPV_0;
    port_vec_t allocPV_1;
    port_vec_t allocPV_2;
    port_vec_t allocPV_3;
    chan_idx_t indir_rank0;
    chan_idx_t indir_rank1;
    chan_idx_t indir_rank2;
    chan_idx_t indir_rank3;
    port_vec_t defl;

    modport master (
        output in_valid, ppv_0, ppv_1, ppv_2, ppv_3,
        input  out_valid, allocPV_0, allocPV_1, allocPV_2, allocPV_3,
        input  indir_rank0, indir_rank1, indir_rank2, indir_rank3, defl
    );

    modport slave (
        input  in_valid, ppv_0, ppv_1, ppv_2, ppv_3,
        output out_valid, allocPV_0, allocPV_1, allocPV_2, allocPV_3,
        output indir_rank0, indir_rank1, indir_rank2, indir_rank3, defl
    );
endinterface

// File: rtl/port_alloc_mc_rank.sv
// One link of the grant chain: serves a single ranked flit from the ports still free.
module port_alloc_mc_rank
    import port_alloc_mc_pkg::*;
(
    input  logic      valid,
    input  port_vec_t ppv,
    input  port_vec_t free_in,
    output port_vec_t grant,
    output port_vec_t free_out,
    output logic      defl
);
    // Productive ports if any remain, otherwise deflect to the lowest free port.
    always_comb begin
        grant = 4'b0000;
        defl  = 1'b0;
        if (!valid) begin
            grant = 4'b0000;
            defl  = 1'b0;
        end else if ((ppv & free_in) != 4'b0000) begin
            grant = ppv & free_in;
            defl  = 1'b0;
        end else begin
            grant = lowest_bit(free_in);
            defl  = 1'b1;
        end
        free_out = free_in & ~grant;
    end
endmodule

// File: rtl/port_alloc_mc.sv
// Registered multicast output-port allocator for the 4-port bufferless router.
// Optional starvation promotion is compiled in with `define STARVE_GUARD_EN.
module port_alloc_mc
    import port_alloc_mc_pkg::*;
(
    input logic            clk,
    input logic            rst_n,
    port_alloc_mc_if.slave bus
);
    chan_idx_t           rr_q, rr_d;
    chan_idx_t           order_s   [NUM_PORT];
    port_vec_t           ppv_arr_s [NUM_PORT];
    port_vec_t           ppv_rank_s[NUM_PORT];
    port_vec_t           grant_s   [NUM_PORT];
    port_vec_t           free_s    [NUM_PORT+1];
    logic [NUM_PORT-1:0] valid_rank_s;
    logic [NUM_PORT-1:0] defl_s;

    logic                out_valid_q, out_valid_d;
    port_vec_t           alloc_q[NUM_PORT], alloc_d[NUM_PORT];
    chan_idx_t           indir_q[NUM_PORT], indir_d[NUM_PORT];
    port_vec_t           defl_q, defl_d;

    assign ppv_arr_s[0] = bus.ppv_0;
    assign ppv_arr_s[1] = bus.ppv_1;
    assign ppv_arr_s[2] = bus.ppv_2;
    assign ppv_arr_s[3] = bus.ppv_3;

`ifdef STARVE_GUARD_EN
    logic [STARVE_W-1:0] cnt_q[NUM_PORT], cnt_d[NUM_PORT];
    logic                starve_hit_s;
    chan_idx_t           starve_ch_s;
    chan_idx_t           starve_pos_s;
    logic [NUM_PORT-1:0] chan_defl_s;

    // Lowest-index channel at or above threshold, and where rr order would place it.
    always_comb begin
        starve_hit_s = 1'b0;
        starve_ch_s  = 2'd0;
        for (int i = NUM_PORT - 1; i >= 0; i--) begin
            if (cnt_q[i] >= STARVE_W'(STARVE_TH)) begin
                starve_hit_s = 1'b1;
                starve_ch_s  = chan_idx_t'(i);
            end else begin
                starve_hit_s = starve_hit_s;
            end
        end
        starve_pos_s = starve_ch_s - rr_q;
    end
`endif

    // Rank k is channel rr+k; a starved channel is pulled to rank 0 and skipped later.
    always_comb begin
        for (int k = 0; k < NUM_PORT; k++) begin
            order_s[k] = rr_q + chan_idx_t'(k);
`ifdef STARVE_GUARD_EN
            if (!starve_hit_s) begin
                order_s[k] = rr_q + chan_idx_t'(k);
            end else if (k == 0) begin
                order_s[k] = starve_ch_s;
            end else if (chan_idx_t'(k - 1) < starve_pos_s) begin
                order_s[k] = rr_q + chan_idx_t'(k - 1);
            end else begin
                order_s[k] = rr_q + chan_idx_t'(k);
            end
`endif
        end
    end

    assign free_s[0] = 4'b1111;

    for (genvar k = 0; k < NUM_PORT; k++) begin : g_rank
        assign valid_rank_s[k] = bus.in_valid[order_s[k]];
        assign ppv_rank_s[k]   = ppv_arr_s[order_s[k]];

        port_alloc_mc_rank u_rank (
            .valid    (valid_rank_s[k]),
            .ppv      (ppv_rank_s[k]),
            .free_in  (free_s[k]),
            .grant    (grant_s[k]),
            .free_out (free_s[k+1]),
            .defl     (defl_s[k])
        );
    end

    // Next values for the pointer and the registered crossbar selects.
    always_comb begin
        out_valid_d = |bus.in_valid;
        defl_d      = defl_s;
        for (int k = 0; k < NUM_PORT; k++) begin
            alloc_d[k] = grant_s[k];
            indir_d[k] = order_s[k];
        end
        if (|bus.in_valid) begin
            rr_d = rr_q + 2'd1;
        end else begin
            rr_d = rr_q;
        end
    end

`ifdef STARVE_GUARD_EN
    // Saturating per-channel deflection count; idle channels hold.
    always_comb begin
        chan_defl_s = 4'b0000;
        for (int k = 0; k < NUM_PORT; k++) begin
            chan_defl_s[order_s[k]] = defl_s[k];
        end
        for (int i = 0; i < NUM_PORT; i++) begin
            if (!bus.in_valid[i]) begin
                cnt_d[i] = cnt_q[i];
            end else if (!chan_defl_s[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] != '1) begin
                cnt_d[i] = cnt_q[i] + STARVE_W'(1);
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Deflection counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORT; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_PORT; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`endif

    // Pointer and output registers; reset drops any in-flight allocation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q        <= 2'd0;
            out_valid_q <= 1'b0;
            defl_q      <= 4'b0000;
            for (int k = 0; k < NUM_PORT; k++) begin
                alloc_q[k] <= 4'b0000;
                indir_q[k] <= 2'd0;
            end
        end else begin
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            defl_q      <= defl_d;
            for (int k = 0; k < NUM_PORT; k++) begin
                alloc_q[k] <= alloc_d[k];
                indir_q[k] <= indir_d[k];
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.allocPV_0   = alloc_q[0];
    assign bus.allocPV_1   = alloc_q[1];
    assign bus.allocPV_2   = alloc_q[2];
    assign bus.allocPV_3   = alloc_q[3];
    assign bus.indir_rank0 = indir_q[0];
    assign bus.indir_rank1 = indir_q[1];
    assign bus.indir_rank2 = indir_q[2];
    assign bus.indir_rank3 = indir_q[3];
    assign bus.defl        = defl_q;
endmodule

// File: tb/tb_port_alloc_mc.sv
// Table-driven bench for port_alloc_mc with an expected-result queue.
// The starvation sequence is built only when STARVE_GUARD_EN is defined.
module tb_port_alloc_mc;
    import port_alloc_mc_pkg::*;

    typedef struct packed {
        logic [3:0]  iv;
        logic [15:0] ppv;   // {ppv_3, ppv_2, ppv_1, ppv_0}
        logic        ov;
        logic [15:0] ap;    // {allocPV_3 .. allocPV_0}
        logic [7:0]  ir;    // {indir_rank3 .. indir_rank0}
        logic [3:0]  defl;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    vec_t vecs[$];
    vec_t exp_q[$];

    port_alloc_mc_if bus ();

    port_alloc_mc dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] iv,
                                input logic [3:0] p3, input logic [3:0] p2,
                                input logic [3:0] p1, input logic [3:0] p0,
                                input logic ov,
                                input logic [3:0] a3, input logic [3:0] a2,
                                input logic [3:0] a1, input logic [3:0] a0,
                                input logic [1:0] r3, input logic [1:0] r2,
                                input logic [1:0] r1, input logic [1:0] r0,
                                input logic [3:0] df);
        vec_t v;
        v.iv   = iv;
        v.ppv  = {p3, p2, p1, p0};
        v.ov   = ov;
        v.ap   = {a3, a2, a1, a0};
        v.ir   = {r3, r2, r1, r0};
        v.defl = df;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic check_all(input string tag, input vec_t e);
        cmp({tag, "_out_valid"}, {15'd0, bus.out_valid}, {15'd0, e.ov});
        cmp({tag, "_allocPV"}, {bus.allocPV_3, bus.allocPV_2, bus.allocPV_1, bus.allocPV_0}, e.ap);
        cmp({tag, "_indir"}, {8'd0, bus.indir_rank3, bus.indir_rank2, bus.indir_rank1, bus.indir_rank0},
            {8'd0, e.ir});
        cmp({tag, "_defl"}, {12'd0, bus.defl}, {12'd0, e.defl});
    endtask

    task automatic set_idle();
        bus.in_valid = 4'b0000;
        bus.ppv_0    = 4'b0000;
        bus.ppv_1    = 4'b0000;
        bus.ppv_2    = 4'b0000;
        bus.ppv_3    = 4'b0000;
    endtask

    // Drive one vector, queue its expectation, then check the registered result.
    task automatic drive(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        bus.in_valid = v.iv;
        bus.ppv_0    = v.ppv[3:0];
        bus.ppv_1    = v.ppv[7:4];
        bus.ppv_2    = v.ppv[11:8];
        bus.ppv_3    = v.ppv[15:12];
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s_scoreboard actual=empty required=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_all(tag, e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        set_idle();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    vec_t zero_v;

    initial begin
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        set_idle();
        zero_v = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0,
                    4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000);
        #1;
        check_all("reset", zero_v);

        // rr: 0,1,2,3,3,3,3,0,1 across these vectors
        vecs.push_back(mk(4'b1111, 4'b1000, 4'b0110, 4'b0001, 4'b0001, 1'b1,
                          4'b1000, 4'b0100, 4'b0010, 4'b0001, 2'd3, 2'd2, 2'd1, 2'd0, 4'b0010));
        vecs.push_back(mk(4'b0111, 4'b1000, 4'b0110, 4'b0001, 4'b0001, 1'b1,
                          4'b1000, 4'b0000, 4'b0110, 4'b0001, 2'd0, 2'd3, 2'd2, 2'd1, 4'b1000));
        vecs.push_back(mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b1,
                          4'b0000, 4'b1111, 4'b0000, 4'b0000, 2'd1, 2'd0, 2'd3, 2'd2, 4'b0000));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 1'b0,
                              4'b0000, 4'b0000, 4'b0000, 4'b0000, 2'd2, 2'd1, 2'd0, 2'd3, 4'b0000));
        vecs.push_back(mk(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1,
                          4'b1000, 4'b0100, 4'b0010, 4'b0001, 2'd2, 2'd1, 2'd0, 2'd3, 4'b1111));
        vecs.push_back(mk(4'b1010, 4'b0100, 4'b0000, 4'b1100, 4'b0000, 1'b1,
                          4'b0001, 4'b0000, 4'b1100, 4'b0000, 2'd3, 2'd2, 2'd1, 2'd0, 4'b1000));
        vecs.push_back(mk(4'b0110, 4'b0000, 4'b0110, 4'b0011, 4'b0000, 1'b1,
                          4'b0000, 4'b0000, 4'b0100, 4'b0011, 2'd0, 2'd3, 2'd2, 2'd1, 4'b0000));

        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive($sformatf("vec%0d", i), vecs[i]);
        end

        // Mid-cycle reset while outputs are valid (rr=2 here).
        drive("pre_rst", mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1,
                            4'b0000, 4'b0010, 4'b0000, 4'b0000, 2'd1, 2'd0, 2'd3, 2'd2, 4'b0000));
        #2;
        rst_n = 1'b0;
        set_idle();
        #1;
        check_all("async_rst", zero_v);
        @(negedge clk);
        rst_n = 1'b1;
        drive("post_rst", mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 1'b1,
                             4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'd3, 2'd2, 2'd1, 2'd0, 4'b0000));

`ifdef STARVE_GUARD_EN
        // Channel 3 (ppv 0) deflected 7 times, rr 0..3,0..2.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            case (i % 4)
                0: drive($sformatf("starve%0d", i), mk(4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b1,
                         4'b0001, 4'b0000, 4'b0000, 4'b1000, 2'd3, 2'd2, 2'd1, 2'd0, 4'b1000));
                1: drive($sformatf("starve%0d", i), mk(4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b1,
                         4'b1000, 4'b0001, 4'b0000, 4'b0000, 2'd0, 2'd3, 2'd2, 2'd1, 4'b0100));
                2: drive($sformatf("starve%0d", i), mk(4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b1,
                         4'b0000, 4'b1000, 4'b0001, 4'b0000, 2'd1, 2'd0, 2'd3, 2'd2, 4'b0010));
                default: drive($sformatf("starve%0d", i), mk(4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b1,
                         4'b0000, 4'b0000, 4'b1000, 4'b0001, 2'd2, 2'd1, 2'd0, 2'd3, 4'b0001));
            endcase
        end
        drive("starve_hold", mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b1,
                                4'b0000, 4'b0000, 4'b1000, 4'b0000, 2'd2, 2'd1, 2'd0, 2'd3, 4'b0000));
        drive("starve_promote", mk(4'b1001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1,
                                   4'b0000, 4'b0000, 4'b0010, 4'b0001, 2'd2, 2'd1, 2'd0, 2'd3, 4'b0010));
        drive("starve_cleared", mk(4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b1,
                                   4'b0000, 4'b0001, 4'b0000, 4'b0000, 2'd0, 2'd3, 2'd2, 2'd1, 4'b0000));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
